uart_sender: RTL and testbench

Serial UART transmitter for the mother board: accepts one byte per valid/ready handshake and shifts it out on `uart_tx` as an 8N1 frame, or 8E1 when parity is compiled in. It is the transmit-side counterpart of the board's UART receive path and uses the same `WAIT` bit-period convention, so a sender and receiver built with equal `WAIT` interoperate directly. It sits between the CPU's output register and the board-level `uart_tx` pin.

---
 rtl/uart_sender_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_sender.sv | 123 ++++++++++++
 tb/tb_uart_sender.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sender_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
// Optional feature macro: UART_SENDER_PARITY_EN (adds the PARITY state).
package uart_package;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_SENDER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts WAIT cycles while run is high and flags the
// last cycle of each period. Held at zero while run is low.
module uart_bit_timer #(
    parameter int WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(WAIT);
    localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

    logic [CW-1:0] cnt;

    // Count 0..WAIT-1, wrapping on every bit boundary; idle keeps it cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_sender.sv
// UART transmitter: one byte per valid/ready handshake, sent as 8N1, or as
// 8E1 when UART_SENDER_PARITY_EN is defined. uart_tx is registered and is
// forced high asynchronously by reset.
module uart_sender
    import uart_package::*;
#(
    parameter int WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       uart_tx
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state, state_nxt;
    logic [UART_DATA_BITS-1:0] shift_q, shift_nxt;
    logic [2:0]                idx_q, idx_nxt;
    logic                      tx_nxt;
    logic                      tick;

`ifdef UART_SENDER_PARITY_EN
    logic par_q;

    // Even parity of the accepted byte, captured before it is shifted away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            par_q <= 1'b0;
        else if (state == IDLE && valid)
            par_q <= ^data;
    end
`endif

    uart_bit_timer #(.WAIT(WAIT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (state != IDLE),
        .tick  (tick)
    );

    assign ready = (state == IDLE);
    assign busy  = !ready;

    // State, shift register, bit index and the registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            idx_q   <= idx_nxt;
            uart_tx <= tx_nxt;
        end
    end

    // Next-state and next line value; the line level for a bit is loaded on
    // the boundary edge so uart_tx only ever changes from a flop.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        idx_nxt   = idx_q;
        tx_nxt    = uart_tx;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt = START;
                    shift_nxt = data;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_nxt = '0;
`ifdef UART_SENDER_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        idx_nxt   = idx_q + 3'd1;
                        shift_nxt = shift_q >> 1;
                        tx_nxt    = shift_q[1];
                    end
                end
            end
`ifdef UART_SENDER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender: table vectors, hand-written corner
// sequences, random bytes, and a line decoder acting as the receive side.
// Follows UART_SENDER_PARITY_EN when the build defines it.
module tb_uart_sender;

    localparam int W = 8;
`ifdef UART_SENDER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] data;
    logic       ready, busy, uart_tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic       fr_q[$];

    uart_sender #(.WAIT(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .data    (data),
        .ready   (ready),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line level expected in bit slot k of a frame carrying b.
    function automatic logic model_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return ((int'(b) / (1 << (k - 1))) % 2) != 0;
        if (k == 9 && NB == 11) return ($countones(b) % 2) != 0;
        return 1'b1;
    endfunction

    // Receiver model: finds a start bit, samples each slot mid-bit, and
    // drops the frame if reset is seen anywhere inside it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                logic [7:0] b;
                logic       ok, abort;
                b = '0; ok = 1'b1; abort = 1'b0;
                repeat (W / 2) begin @(negedge clk); if (reset) abort = 1'b1; end
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int k = 1; k < NB; k++) begin
                    repeat (W) begin @(negedge clk); if (reset) abort = 1'b1; end
                    if (k <= 8) b[k-1] = uart_tx;
                    else if (k == 9 && NB == 11) begin
                        if (uart_tx !== ^b) ok = 1'b0;
                    end else if (uart_tx !== 1'b1) ok = 1'b0;
                end
                if (!abort) begin
                    rx_q.push_back(b);
                    fr_q.push_back(ok);
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!ready && guard < 40 * W) begin step(1); guard++; end
        chk("ready_wait", ready, 1);
    endtask

    task automatic check_rx(input logic [7:0] b);
        if (rx_q.size() == 0) chk("rx_present", 0, 1);
        else begin
            chk("rx_byte", rx_q.pop_front(), b);
            chk("rx_framing", fr_q.pop_front(), 1);
        end
    endtask

    // Send one byte; checks each slot mid-bit and the busy length. inj_c
    // pulses valid with 0xFF at that frame cycle (-1 = never).
    task automatic send(input logic [7:0] b, input logic [10:0] exp_line, input int inj_c);
        int c;
        wait_ready();
        valid = 1'b1; data = b;
        step(1);
        valid = 1'b0; data = ~b;
        c = 0;
        while (c < 20 * W) begin
            if (c == inj_c) begin valid = 1'b1; data = 8'hFF; end
            else if (c == inj_c + 1) valid = 1'b0;
            if (c == 0) begin
                chk("start_edge_tx", uart_tx, 0);
                chk("start_edge_busy", busy, 1);
            end
            if (c % W == W / 2 && c / W < NB)
                chk($sformatf("slot%0d_byte%02h", c / W, b), uart_tx, exp_line[c/W]);
            if (ready) break;
            step(1); c++;
        end
        valid = 1'b0;
        chk("frame_len", c, NB * W);
        check_rx(b);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // 8N1 slots, bit k = slot k (start at bit 0)
        logic       par;
    } vec_t;

    vec_t tv[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp;
        int lows;
        tv[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
        tv[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
        tv[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        tv[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
        tv[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
        tv[5] = '{8'h41, 10'b1_01000001_0, 1'b0};

        reset = 1'b1; valid = 1'b0; data = '0;
        step(3);
        chk("reset_tx", uart_tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        @(negedge clk) reset = 1'b0;
        step(2);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            if (NB == 11) exp = {tv[i].line[9], tv[i].par, tv[i].line[8:0]};
            else          exp = {1'b0, tv[i].line};
            send(tv[i].data, exp, -1);
            step(2);
        end

        // Back-to-back with valid held: next start one idle cycle later
        wait_ready();
        valid = 1'b1; data = 8'hA5;
        step(1);
        data = 8'h3C;
        step(NB * W - 1);
        chk("b2b_last_stop_tx", uart_tx, 1);
        chk("b2b_last_stop_ready", ready, 0);
        step(1);
        chk("b2b_gap_tx", uart_tx, 1);
        chk("b2b_gap_ready", ready, 1);
        step(1);
        chk("b2b_second_start_tx", uart_tx, 0);
        chk("b2b_second_start_ready", ready, 0);
        valid = 1'b0;
        wait_ready();
        check_rx(8'hA5);
        check_rx(8'h3C);

        // valid during DATA is ignored
        for (int k = 0; k < NB; k++) exp[k] = model_bit(8'h00, k);
        send(8'h00, exp, 3 * W + 2);
        lows = 0;
        for (int i = 0; i < 3 * W; i++) begin step(1); if (!uart_tx) lows++; end
        chk("ignored_valid_lows", lows, 0);
        chk("ignored_valid_ready", ready, 1);
        chk("ignored_valid_rx_count", rx_q.size(), 0);

        // Reset mid-frame
        wait_ready();
        valid = 1'b1; data = 8'h00;
        step(1);
        valid = 1'b0;
        step(30);
        reset = 1'b1;
        #1;
        chk("midreset_tx", uart_tx, 1);
        chk("midreset_ready", ready, 1);
        step(5);
        @(negedge clk) reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin step(1); if (!uart_tx) lows++; end
        chk("post_reset_lows", lows, 0);
        chk("post_reset_ready", ready, 1);
        chk("post_reset_rx_count", rx_q.size(), 0);

        // Random bytes against the model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            step($urandom_range(0, 5));
            for (int k = 0; k < NB; k++) exp[k] = model_bit(b, k);
            send(b, exp, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
